fpu_pack_d2s_pair: RTL

Packs the 32-bit single-precision results from the low-cost double-to-single converter into 64-bit packed-single words, two lanes per word, for the FPU writeback and store path.
- Sits directly downstream of the converter.
- Uses a valid/ready handshake on both sides.
- A `inLast` marker flushes a half-filled word.
- Keeps a sticky overflow-to-infinity flag and a packed-word counter for the FPU status logic.

---
 rtl/fpu_pack_d2s_pair.sv | 82 ++++++++
 1 files changed

// File: rtl/fpu_pack_d2s_pair.sv
// Packs two converted single-precision lanes into one 64-bit packed-single word.
// Tracks a sticky overflow-to-infinity flag and a handed-off word counter.
module fpu_pack_d2s_pair #(
  parameter logic [31:0] PAD_HI = 32'h0000_0000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic [31:0]      inData,
  input  logic             inLast,
  output logic             inReady,
  output logic             outValid,
  output logic [63:0]      outData,
  output logic [1:0]       outMask,
  input  logic             outReady,
  output logic             stInf,
  input  logic             clrSticky,
  output logic [CNT_W-1:0] wordCnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state;
  logic [31:0] holdLane;
  logic        accept;
  logic        handoff;
  logic        slotFree;
  logic        laneInf;

  assign outValid = (state == FULL);
  assign inReady  = (state != FULL) || outReady;
  assign accept   = inValid && inReady;
  assign handoff  = outValid && outReady;
  assign laneInf  = (inData[30:0] == 31'h7F80_0000);

  // A FULL word leaving this edge frees the slot as if we were EMPTY
  assign slotFree = (state == EMPTY) || handoff;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      holdLane <= '0;
      outData  <= '0;
      outMask  <= '0;
      stInf    <= 1'b0;
      wordCnt  <= '0;
    end else begin
      if (handoff)
        wordCnt <= wordCnt + 1'b1;

      if (accept && laneInf)
        stInf <= 1'b1;
      else if (clrSticky)
        stInf <= 1'b0;

      unique case (1'b1)
        accept && slotFree && inLast: begin
          outData <= {PAD_HI, inData};
          outMask <= 2'b01;
          state   <= FULL;
        end
        accept && slotFree && !inLast: begin
          holdLane <= inData;
          state    <= HALF;
        end
        accept && !slotFree: begin
          outData <= {inData, holdLane};
          outMask <= 2'b11;
          state   <= FULL;
        end
        !accept && handoff: begin
          state <= EMPTY;
        end
        default: ;
      endcase
    end
  end

endmodule
